// File: rtl/v2_pulse_gen.sv
// Synthetic exponential-pulse source for self-test of the v2 shaping filter chain.
// Injects a programmable pulse train into a decaying fixed-point accumulator.
package package_settings;
   parameter int SIZE_ADC_DATA = 12;
endpackage

module v2_pulse_gen
   import package_settings::*;
#(
   parameter int          DATA_W      = SIZE_ADC_DATA,
   parameter int          FRAC_W      = 8,
   parameter int          DECAY_SHIFT = 5,
   parameter int          PERIOD_W    = 16,
   parameter int unsigned BASELINE    = 0
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic [DATA_W-1:0]   amplitude,
   input  logic [PERIOD_W-1:0] period,
   input  logic [7:0]          count,
   output logic [DATA_W-1:0]   output_data,
   output logic                pulse_strobe,
   output logic                busy,
   output logic                done,
   output logic [1:0]          o_dbg_state
);

   localparam int ACC_W = DATA_W + FRAC_W;
   localparam logic [DATA_W-1:0] BASE_V = DATA_W'(BASELINE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [ACC_W-1:0]    r_acc;
   logic [DATA_W-1:0]   r_amp;
   logic [PERIOD_W-1:0] r_per;
   logic [PERIOD_W-1:0] r_pcnt;
   logic [7:0]          r_rem;

   logic                w_inj;
   logic [ACC_W-1:0]    w_decayed;
   logic [ACC_W:0]      w_acc_sum;
   logic [ACC_W-1:0]    w_acc_n;
   logic                w_drain_end;
   logic [DATA_W:0]     w_out_sum;
   logic [DATA_W-1:0]   w_out_sat;

   // start is a one-cycle request honoured only in IDLE; stop is honoured only
   // in RUN and beats an injection due in the same cycle.

   // Decay, optional injection, then clamp the accumulator to all-ones.
   always_comb begin
      w_decayed   = r_acc - (r_acc >> DECAY_SHIFT);
      w_acc_sum   = {1'b0, w_decayed} +
                    (w_inj ? {1'b0, r_amp, {FRAC_W{1'b0}}} : {(ACC_W+1){1'b0}});
      w_acc_n     = w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
      w_drain_end = (r_state == S_DRAIN) && (w_acc_n[ACC_W-1:FRAC_W] == '0);
      w_out_sum   = {1'b0, BASE_V} + {1'b0, w_acc_n[ACC_W-1:FRAC_W]};
      w_out_sat   = w_out_sum[DATA_W] ? {DATA_W{1'b1}} : w_out_sum[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_next_state = S_RUN;
         end
         S_RUN: begin
            if (stop)                        w_next_state = S_DRAIN;
            else if (w_inj && r_rem == 8'd1) w_next_state = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_drain_end) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_inj       = (r_state == S_RUN) && (r_pcnt == '0) && !stop;
      busy        = (r_state != S_IDLE);
      o_dbg_state = r_state;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc        <= '0;
         r_amp        <= '0;
         r_per        <= '0;
         r_pcnt       <= '0;
         r_rem        <= '0;
         output_data  <= BASE_V;
         pulse_strobe <= 1'b0;
         done         <= 1'b0;
      end else begin
         pulse_strobe <= w_inj;
         done         <= w_drain_end;
         output_data  <= w_out_sat;
         r_acc        <= (r_state == S_IDLE || w_drain_end) ? '0 : w_acc_n;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_amp  <= amplitude;
                  r_per  <= (period == '0) ? PERIOD_W'(1) : period;
                  r_rem  <= count;
                  r_pcnt <= '0;
               end
            end
            S_RUN: begin
               // rem == 0 is continuous mode and is never counted down.
               if (w_inj) begin
                  r_pcnt <= r_per - PERIOD_W'(1);
                  if (r_rem > 8'd1) r_rem <= r_rem - 8'd1;
               end else if (r_pcnt != '0) begin
                  r_pcnt <= r_pcnt - PERIOD_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_v2_pulse_gen.sv
// Directed bench for v2_pulse_gen: a time-based reference model checked every
// cycle, plus hand-computed literal checks for each scenario.
module tb_v2_pulse_gen;

  localparam int DATA_W   = 12;
  localparam int FRAC_W   = 8;
  localparam int DS       = 5;
  localparam int PERIOD_W = 16;
  localparam int BASE     = 0;
  localparam longint ACC_MAX = (longint'(1) << (DATA_W + FRAC_W)) - 1;
  localparam longint OUT_MAX = (longint'(1) << DATA_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic                clk;
  logic                rst_n;
  logic                start;
  logic                stop;
  logic [DATA_W-1:0]   amplitude;
  logic [PERIOD_W-1:0] period;
  logic [7:0]          count;
  logic [DATA_W-1:0]   output_data;
  logic                pulse_strobe;
  logic                busy;
  logic                done;
  logic [1:0]          dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  v2_pulse_gen #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .DECAY_SHIFT(DS),
    .PERIOD_W(PERIOD_W), .BASELINE(BASE)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .stop(stop),
    .amplitude(amplitude), .period(period), .count(count),
    .output_data(output_data), .pulse_strobe(pulse_strobe),
    .busy(busy), .done(done), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests;
  int n_fail;
  bit chk_en;
  int k;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 idle, 1 run, 2 drain. Injections are scheduled by absolute cycle.
  int     m_mode;
  longint m_acc, m_acc_n, m_amp, m_per, m_cyc, m_next;
  int     m_total, m_ninj;
  bit     m_inj, m_was_drain;
  longint m_out;
  bit     m_strobe, m_busy, m_done;
  int     m_state;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_acc = 0; m_cyc = 0; m_next = 0; m_amp = 0; m_per = 1;
      m_total = 0; m_ninj = 0;
      m_out = BASE; m_strobe = 0; m_busy = 0; m_done = 0; m_state = 0;
    end else begin
      m_cyc++;
      m_inj = 0;
      m_was_drain = (m_mode == 2);
      case (m_mode)
        0: if (start) begin
             m_amp   = amplitude;
             m_per   = (period == 0) ? 1 : period;
             m_total = count;
             m_ninj  = 0;
             m_next  = m_cyc + 1;
             m_mode  = 1;
           end
        1: if (stop) m_mode = 2;
           else if (m_cyc == m_next) begin
             m_inj = 1;
             m_ninj++;
             m_next = m_cyc + m_per;
             if (m_total != 0 && m_ninj == m_total) m_mode = 2;
           end
        default: ;
      endcase
      m_acc_n = m_acc - (m_acc >> DS) + (m_inj ? (m_amp << FRAC_W) : 0);
      if (m_acc_n > ACC_MAX) m_acc_n = ACC_MAX;
      m_out = BASE + (m_acc_n >> FRAC_W);
      if (m_out > OUT_MAX) m_out = OUT_MAX;
      m_done = 0;
      if (m_was_drain && (m_acc_n >> FRAC_W) == 0) begin
        m_done  = 1;
        m_acc_n = 0;
        m_mode  = 0;
      end
      if (m_mode == 0) m_acc_n = 0;
      m_acc    = m_acc_n;
      m_strobe = m_inj;
      m_busy   = (m_mode != 0);
      m_state  = m_mode;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("cyc_output_data", output_data, m_out);
      chk("cyc_pulse_strobe", pulse_strobe, m_strobe);
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_state", dbg_state, m_state);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    k++;
  endtask

  // Leaves the bench at the negedge after the start-sampling edge (k = 0).
  task automatic start_run(input int amp, input int per, input int cnt);
    amplitude = DATA_W'(amp);
    period    = PERIOD_W'(per);
    count     = 8'(cnt);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    chk("start_busy", busy, 1);
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      step();
      n++;
    end
    chk({name, "_done_seen"}, done, 1);
    chk({name, "_busy_in_done"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  int strobes[$];
  int exp_k[4];
  int prev;
  bit mono_bad;
  int n;

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 0; k = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    amplitude = '0; period = '0; count = '0;
    repeat (3) @(negedge clk);
    chk("reset_output", output_data, BASE);
    chk("reset_strobe", pulse_strobe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) step();

    // Single pulse and decay; a start during DRAIN must be ignored.
    start_run(1000, 100, 1);
    step();
    chk("single_first", output_data, 1000);
    chk("single_strobe", pulse_strobe, 1);
    step();
    chk("single_second", output_data, 968);
    chk("single_state_drain", dbg_state, 2);
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    prev = output_data; mono_bad = 0; n = 0;
    while (!done && n < 3000) begin
      step();
      if (int'(output_data) > prev) mono_bad = 1;
      prev = output_data;
      n++;
    end
    chk("single_monotonic", mono_bad, 0);
    chk("single_done_seen", done, 1);
    chk("single_busy_in_done", busy, 0);
    chk("single_final_zero", output_data, 0);
    repeat (3) step();

    // Pulse train spacing.
    start_run(500, 40, 4);
    strobes.delete();
    n = 0;
    while (!done && n < 3000) begin
      step();
      if (pulse_strobe) strobes.push_back(k);
      n++;
    end
    chk("train_done_seen", done, 1);
    chk("train_strobe_count", strobes.size(), 4);
    exp_k = '{1, 41, 81, 121};
    for (int i = 0; i < 4; i++)
      chk("train_strobe_time", (i < strobes.size()) ? strobes[i] : -1, exp_k[i]);
    repeat (2) step();

    // Pileup saturation.
    start_run(3000, 1, 2);
    step();
    chk("pileup_first", output_data, 3000);
    step();
    chk("pileup_saturated", output_data, 4095);
    chk("pileup_state_drain", dbg_state, 2);
    step();
    chk("pileup_decay", output_data, 3968);
    wait_done("pileup", 3000);
    repeat (2) step();

    // Continuous mode stopped exactly when an injection is due (k = 21).
    start_run(300, 10, 0);
    repeat (20) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_no_strobe", pulse_strobe, 0);
    chk("stop_state_drain", dbg_state, 2);
    wait_done("stop", 3000);

    // Start issued in the done cycle is accepted; a later start during RUN is ignored.
    start_run(200, 20, 3);
    step();
    chk("busy_start_first", output_data, 200);
    repeat (4) step();
    amplitude = DATA_W'(50); period = PERIOD_W'(3); count = 8'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    strobes.delete();
    strobes.push_back(1);
    n = 0;
    while (!done && n < 3000) begin
      step();
      if (pulse_strobe) strobes.push_back(k);
      n++;
    end
    chk("busy_start_done_seen", done, 1);
    chk("busy_start_strobes", strobes.size(), 3);
    repeat (2) step();

    // Asynchronous reset in the middle of RUN.
    start_run(700, 30, 5);
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_output", output_data, BASE);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_strobe", pulse_strobe, 0);
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    stop = 1'b1;
    n = 0;
    repeat (40) begin
      step();
      if (busy || pulse_strobe || output_data != BASE) n++;
    end
    stop = 1'b0;
    chk("rst_after_quiet", n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
